// File: rtl/rate_demod.sv
// rate_demod: counts rate-multiplier pulses (Zin) over a window of
// 2^WIN_LOG2 qualified strobes (X) and presents the count on C with a
// Valid/Ack handshake and a sticky overrun flag.
module rate_demod #(
  parameter int WIN_LOG2 = 8,
  parameter bit CONT     = 1'b1
) (
  input  logic              CLK,
  input  logic              Clear_N,
  input  logic              Start,
  input  logic              X,
  input  logic              Zin,
  input  logic              Ack,
  output logic [WIN_LOG2:0] C,
  output logic              Valid,
  output logic              Ovr,
  output logic              Busy
);

  typedef enum logic {IDLE, MEAS} state_t;

  state_t              r_state;
  state_t              w_nextState;
  logic [WIN_LOG2-1:0] r_wc;
  logic [WIN_LOG2:0]   r_pc;
  logic [WIN_LOG2:0]   r_c;
  logic                r_valid;
  logic                r_ovr;

  logic                w_strobe;
  logic                w_lastSlot;
  logic                w_winEnd;
  logic                w_ackEff;
  logic [WIN_LOG2:0]   w_zinExt;

  // A strobe only counts while measuring; a restart on the same edge
  // suppresses the window end so the partial result is dropped.
  assign w_strobe   = (r_state == MEAS) && X;
  assign w_lastSlot = (r_wc == '1);
  assign w_winEnd   = w_strobe && w_lastSlot && !Start;
  assign w_ackEff   = Ack && r_valid;
  assign w_zinExt   = {{WIN_LOG2{1'b0}}, Zin};

  // State register.
  always_ff @(posedge CLK) begin
    if (!Clear_N) r_state <= IDLE;
    else          r_state <= w_nextState;
  end

  // Next-state logic: Start always (re)enters MEAS; single-shot mode
  // returns to IDLE once a window completes.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: if (Start) w_nextState = MEAS;
      MEAS: begin
        if (Start)                 w_nextState = MEAS;
        else if (w_winEnd && !CONT) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Window and pulse counters; both wrap to zero at the last strobe.
  always_ff @(posedge CLK) begin
    if (!Clear_N) begin
      r_wc <= '0;
      r_pc <= '0;
    end else if (Start) begin
      r_wc <= '0;
      r_pc <= '0;
    end else if (w_strobe) begin
      if (w_lastSlot) begin
        r_wc <= '0;
        r_pc <= '0;
      end else begin
        r_wc <= r_wc + WIN_LOG2'(1);
        r_pc <= r_pc + w_zinExt;
      end
    end
  end

  // Result register and handshake: a completing window always loads C and
  // sets Valid, otherwise an Ack of a pending result clears Valid.
  always_ff @(posedge CLK) begin
    if (!Clear_N) begin
      r_c     <= '0;
      r_valid <= 1'b0;
    end else if (w_winEnd) begin
      r_c     <= r_pc + w_zinExt;
      r_valid <= 1'b1;
    end else if (w_ackEff) begin
      r_valid <= 1'b0;
    end
  end

  // Sticky overrun: set when an unacknowledged result is overwritten,
  // cleared only by Start or reset.
  always_ff @(posedge CLK) begin
    if (!Clear_N)                         r_ovr <= 1'b0;
    else if (Start)                       r_ovr <= 1'b0;
    else if (w_winEnd && r_valid && !Ack) r_ovr <= 1'b1;
  end

  assign C     = r_c;
  assign Valid = r_valid;
  assign Ovr   = r_ovr;
  assign Busy  = (r_state == MEAS);

endmodule

// File: tb/tb_rate_demod.sv
// Testbench for rate_demod: one continuous and one single-shot instance
// share the same stimulus. A window-of-samples reference model predicts
// the outputs after every edge; a monitor pops and compares them.
module tb_rate_demod;

  localparam int W   = 8;
  localparam int WIN = 1 << W;

  logic         clk;
  logic         clearN, startIn, xIn, zinIn, ackIn;
  logic [W:0]   cC, cS;
  logic         validC, ovrC, busyC, validS, ovrS, busyS;

  int checks = 0;
  int passes = 0;

  rate_demod #(.WIN_LOG2(W), .CONT(1'b1)) dutC (
    .CLK(clk), .Clear_N(clearN), .Start(startIn), .X(xIn), .Zin(zinIn),
    .Ack(ackIn), .C(cC), .Valid(validC), .Ovr(ovrC), .Busy(busyC)
  );

  rate_demod #(.WIN_LOG2(W), .CONT(1'b0)) dutS (
    .CLK(clk), .Clear_N(clearN), .Start(startIn), .X(xIn), .Zin(zinIn),
    .Ack(ackIn), .C(cS), .Valid(validS), .Ovr(ovrS), .Busy(busyS)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int k;
    int c;
    bit valid;
    bit ovr;
    bit busy;
  } exp_t;

  exp_t expQ[$];

  // Reference model: record every counted Zin sample of the current window,
  // and when the window is full, sum the samples to form the result.
  int mC[2];
  bit mValid[2];
  bit mOvr[2];
  bit mBusy[2];
  bit mCont[2];
  bit samp[2][WIN];
  int nSamp[2];

  task automatic modelStep(input int k);
    bit ackEff;
    int sum;
    ackEff = ackIn && mValid[k];
    if (!clearN) begin
      mBusy[k] = 0; mValid[k] = 0; mOvr[k] = 0; mC[k] = 0; nSamp[k] = 0;
    end else if (startIn) begin
      nSamp[k] = 0; mBusy[k] = 1; mOvr[k] = 0;
      if (ackEff) mValid[k] = 0;
    end else if (mBusy[k] && xIn) begin
      samp[k][nSamp[k]] = zinIn;
      nSamp[k]++;
      if (nSamp[k] == WIN) begin
        sum = 0;
        for (int i = 0; i < WIN; i++) sum += int'(samp[k][i]);
        if (mValid[k] && !ackIn) mOvr[k] = 1;
        mC[k] = sum;
        mValid[k] = 1;
        nSamp[k] = 0;
        if (!mCont[k]) mBusy[k] = 0;
      end else if (ackEff) begin
        mValid[k] = 0;
      end
    end else if (ackEff) begin
      mValid[k] = 0;
    end
  endtask

  // One clock of stimulus; the model advances on the same edge and its
  // prediction is queued for the monitor.
  task automatic applyStimulus(input bit iClr, input bit iStart, input bit iX,
                               input bit iZin, input bit iAck);
    exp_t e;
    clearN = iClr; startIn = iStart; xIn = iX; zinIn = iZin; ackIn = iAck;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      modelStep(k);
      e.k = k; e.c = mC[k]; e.valid = mValid[k]; e.ovr = mOvr[k]; e.busy = mBusy[k];
      expQ.push_back(e);
    end
    #1;
  endtask

  // n strobes; zmode 0=all 0, 1=all 1, 2=alternate 1,0 with X=0 gaps (Zin=1)
  task automatic runStrobes(input int n, input int zmode);
    for (int i = 0; i < n; i++) begin
      if (zmode == 2 && (i % 10) == 5) begin
        applyStimulus(1, 0, 0, 1, 0);
        applyStimulus(1, 0, 0, 1, 0);
      end
      applyStimulus(1, 0, 1, (zmode == 1) || (zmode == 2 && (i % 2) == 0), 0);
    end
  endtask

  task automatic expectVal(input string name, input int act, input int want);
    checks++;
    if (act == want) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, want);
  endtask

  // Compare one queued prediction against the matching instance.
  task automatic checkOutput(input exp_t e);
    int c; bit v, o, b;
    if (e.k == 0) begin c = int'(cC); v = validC; o = ovrC; b = busyC; end
    else          begin c = int'(cS); v = validS; o = ovrS; b = busyS; end
    checks++;
    if (c == e.c && v == e.valid && o == e.ovr && b == e.busy) passes++;
    else $display("[TB] FAIL out%0d: got C=%0d V=%0b O=%0b B=%0b, expected C=%0d V=%0b O=%0b B=%0b",
                  e.k, c, v, o, b, e.c, e.valid, e.ovr, e.busy);
  endtask

  // Monitor: outputs are presented every cycle; compare on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      while (expQ.size() > 0) checkOutput(expQ.pop_front());
    end
  end

  initial begin
    mCont[0] = 1; mCont[1] = 0;
    for (int k = 0; k < 2; k++) begin
      mC[k] = 0; mValid[k] = 0; mOvr[k] = 0; mBusy[k] = 0; nSamp[k] = 0;
    end
    clearN = 0; startIn = 0; xIn = 0; zinIn = 0; ackIn = 0;

    // Reset, including a Start that reset must override.
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 1, 1);
    expectVal("reset_busy", busyC, 0);
    expectVal("reset_c", int'(cC), 0);

    // X/Zin ignored in IDLE.
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 1, 1, 0);
    expectVal("idle_valid", validC, 0);

    // Full window of ones.
    applyStimulus(1, 1, 0, 0, 0);
    runStrobes(WIN, 1);
    expectVal("ones_c", int'(cC), 256);
    expectVal("ones_valid", validC, 1);
    expectVal("ones_ovr", ovrC, 0);
    expectVal("single_busy", busyS, 0);

    // Alternating Zin with X=0 gaps carrying Zin=1.
    applyStimulus(1, 0, 0, 0, 1);
    applyStimulus(1, 1, 0, 0, 0);
    runStrobes(WIN, 2);
    expectVal("alt_c", int'(cC), 128);

    // Two unacknowledged windows of zeros -> overrun; Start clears it.
    applyStimulus(1, 0, 0, 0, 1);
    applyStimulus(1, 1, 0, 0, 0);
    runStrobes(2 * WIN, 0);
    expectVal("ovr_c", int'(cC), 0);
    expectVal("ovr_valid", validC, 1);
    expectVal("ovr_set", ovrC, 1);
    applyStimulus(1, 1, 0, 0, 0);
    expectVal("ovr_cleared", ovrC, 0);

    // Ack on the exact window-end edge.
    runStrobes(WIN - 1, 1);
    applyStimulus(1, 0, 1, 1, 1);
    expectVal("ackend_c", int'(cC), 256);
    expectVal("ackend_valid", validC, 1);
    expectVal("ackend_ovr", ovrC, 0);

    // Reset mid-window, then a fresh window.
    applyStimulus(1, 1, 0, 0, 0);
    runStrobes(100, 1);
    applyStimulus(0, 1, 1, 1, 1);
    expectVal("midrst_c", int'(cC), 0);
    expectVal("midrst_valid", validC, 0);
    expectVal("midrst_busy", busyC, 0);
    applyStimulus(1, 1, 0, 0, 0);
    runStrobes(WIN, 1);
    expectVal("postrst_c", int'(cC), 256);

    // Single-shot: idle activity, then restart 37 strobes in.
    for (int i = 0; i < 20; i++) applyStimulus(1, 0, 1, 0, 0);
    expectVal("shot_hold_c", int'(cS), 256);
    applyStimulus(1, 1, 0, 0, 0);
    runStrobes(37, 1);
    applyStimulus(1, 1, 0, 0, 0);
    expectVal("restart_c", int'(cS), 256);
    runStrobes(WIN, 0);
    expectVal("restart_new_c", int'(cS), 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++)
      applyStimulus($urandom_range(999) != 0, $urandom_range(599) == 0,
                    $urandom_range(3) != 0, 1'($urandom_range(1)),
                    $urandom_range(29) == 0);

    @(negedge clk);
    #1;
    expectVal("queue_drained", expQ.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
